seq_divider: RTL



---
 rtl/seq_divider_pkg.sv | 25 ++
 rtl/seq_div_step.sv | 33 +++
 rtl/seq_divider.sv | 108 ++++++++++
 3 files changed

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider (and the multiplier unit).
//   - DIV_WIDTH / DIV_CNT_W : default operand width and iteration counter width
//   - ST_* : FSM state encodings used by seq_divider
//   - twosNeg / absVal : two's-complement negate and magnitude helpers.
//     The magnitude is unsigned in DIV_WIDTH bits, so absVal(-2^(W-1))
//     returns 2^(W-1), which is the value the divider needs.
package seq_divider_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 6;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  function automatic logic [DIV_WIDTH-1:0] twosNeg(input logic [DIV_WIDTH-1:0] x);
    return ~x + 1'b1;
  endfunction

  function automatic logic [DIV_WIDTH-1:0] absVal(input logic [DIV_WIDTH-1:0] x);
    return x[DIV_WIDTH-1] ? twosNeg(x) : x;
  endfunction

endpackage

// File: rtl/seq_div_step.sv
// One combinational restoring-division iteration.
// Ports:
//   remIn  : partial remainder before this step (always < dvsMag)
//   dvdIn  : remaining dividend bits (MSB next) with quotient bits filling from the LSB
//   dvsMag : unsigned divisor magnitude
//   remOut : partial remainder after this step
//   dvdOut : dvdIn shifted left by one with the new quotient bit in the LSB
module seq_div_step
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] remIn,
  input  logic [WIDTH-1:0] dvdIn,
  input  logic [WIDTH-1:0] dvsMag,
  output logic [WIDTH-1:0] remOut,
  output logic [WIDTH-1:0] dvdOut
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           negative;

  // Since remIn < dvsMag <= 2^(WIDTH-1), the shifted value stays below 2^WIDTH,
  // so the top bit of the (WIDTH+1)-bit difference is a reliable borrow.
  assign shifted  = {1'b0, remIn[WIDTH-1:0]} << 1 | {{WIDTH{1'b0}}, dvdIn[WIDTH-1]};
  assign diff     = shifted - {1'b0, dvsMag};
  assign negative = diff[WIDTH];

  assign remOut = negative ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign dvdOut = {dvdIn[WIDTH-2:0], ~negative};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed divider with MIPS DIV semantics (quotient -> LO,
// remainder -> HI). Quotient truncates toward zero, remainder takes the
// sign of the dividend.
// Handshake: div_start is a request pulse honoured only while idle; the
// operands are captured on that edge. div_busy stays high from the next
// cycle until the done cycle ends; div_done pulses for one cycle when the
// result is available, with div_zero alongside it if the divisor was zero.
// Requests while busy are dropped, not queued.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   div_start            : request pulse
//   dividend, divisor    : signed operands
//   quotient, remainder  : registered signed results (hold until next success)
//   div_busy, div_done, div_zero : status
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_busy,
  output logic             div_done,
  output logic             div_zero
);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] remReg;
  logic [WIDTH-1:0] dvdReg;   // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0] dvsMag;
  logic             signQ;
  logic             signR;
  logic             zeroFlag;

  logic [WIDTH-1:0] remNext;
  logic [WIDTH-1:0] dvdNext;

  seq_div_step #(.WIDTH(WIDTH)) stepInst (
    .remIn  (remReg),
    .dvdIn  (dvdReg),
    .dvsMag (dvsMag),
    .remOut (remNext),
    .dvdOut (dvdNext)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      remReg    <= '0;
      dvdReg    <= '0;
      dvsMag    <= '0;
      signQ     <= 1'b0;
      signR     <= 1'b0;
      zeroFlag  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (div_start) begin
            if (divisor == '0) begin
              zeroFlag <= 1'b1;
              state    <= ST_DONE;
            end else begin
              dvdReg <= absVal(dividend);
              dvsMag <= absVal(divisor);
              remReg <= '0;
              signQ  <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
              signR  <= dividend[WIDTH-1];
              cnt    <= CNT_W'(WIDTH);
              state  <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          remReg <= remNext;
          dvdReg <= dvdNext;
          cnt    <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          quotient  <= signQ ? twosNeg(dvdReg) : dvdReg;
          remainder <= signR ? twosNeg(remReg) : remReg;
          state     <= ST_DONE;
        end
        default: begin  // ST_DONE
          zeroFlag <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign div_busy = (state != ST_IDLE);
  assign div_done = (state == ST_DONE);
  assign div_zero = (state == ST_DONE) && zeroFlag;

endmodule
